// File: rtl/params_noc.sv
// Shared NoC definitions: port directions, flit format, VC state encoding
// and the XY routing function used by the input VC units.
package params_noc;

    localparam int in_Port_Cnt = 5;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } inout_Port;

    localparam int coord_W   = 4;
    localparam int vc_id_W   = 2;
    localparam int payload_W = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t             ftype;
        logic [vc_id_W-1:0]     vc_id;
        logic [coord_W-1:0]     dest_x;
        logic [coord_W-1:0]     dest_y;
        logic [payload_W-1:0]   payload;
    } flit_t;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_t;

    // Dimension-ordered routing: resolve X first, then Y, else eject locally.
    function automatic inout_Port xy_route(input logic [coord_W-1:0] dest_x,
                                           input logic [coord_W-1:0] dest_y,
                                           input logic [coord_W-1:0] cur_x,
                                           input logic [coord_W-1:0] cur_y);
        inout_Port dir;
        if (dest_x > cur_x)      dir = EAST;
        else if (dest_x < cur_x) dir = WEST;
        else if (dest_y > cur_y) dir = NORTH;
        else if (dest_y < cur_y) dir = SOUTH;
        else                     dir = LOCAL;
        return dir;
    endfunction

    function automatic logic is_head(input flit_type_t t);
        return (t == HEAD) || (t == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_type_t t);
        return (t == TAIL) || (t == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC flit buffer. Push and pop may coincide, including when full;
// a push into a full FIFO without a simultaneous pop is refused.
module vc_fifo
    import params_noc::*;
#(
    parameter int buff_Depth = 4
)
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  flit_t push_data,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output flit_t front
);

    localparam int ptr_W = $clog2(buff_Depth);

    flit_t            mem [buff_Depth];
    logic [ptr_W-1:0] rd_ptr;
    logic [ptr_W-1:0] wr_ptr;
    logic [ptr_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (ptr_W+1)'(buff_Depth));
    assign empty   = (count == '0);
    assign front   = mem[rd_ptr];

    // Flit storage needs no reset; occupancy is governed by the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_W'(1);
            if (do_push && !do_pop)      count <= count + (ptr_W+1)'(1);
            else if (do_pop && !do_push) count <= count - (ptr_W+1)'(1);
        end
    end

endmodule

// File: rtl/input_vc_unit.sv
// Input-port virtual-channel unit: buffers flits per VC, routes head flits
// with XY routing, requests the switch allocator and dequeues on grant,
// returning one credit upstream for every flit that leaves a VC buffer.
module input_vc_unit
    import params_noc::*;
#(
    parameter int vc_Num     = 4,
    parameter int buff_Depth = 4,
    parameter int cur_X      = 0,
    parameter int cur_Y      = 0
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  flit_t             flit_i,
    output logic [vc_Num-1:0] credit_o,
    output logic [vc_Num-1:0] request_o,
    output inout_Port         out_port_o [vc_Num-1:0],
    input  logic [vc_Num-1:0] grant_i,
    output logic              valid_o,
    output flit_t             flit_o,
    output logic              error_o
);

    logic [vc_Num-1:0] push;
    logic [vc_Num-1:0] pop;
    logic [vc_Num-1:0] full;
    logic [vc_Num-1:0] empty;
    logic [vc_Num-1:0] grant_pop;
    logic [vc_Num-1:0] discard;
    flit_t             front [vc_Num];
    vc_state_t         state [vc_Num];
    flit_t             sel_flit;
    logic              grant_err;
    logic              drop_err;

    for (genvar v = 0; v < vc_Num; v++) begin : g_vc
        vc_fifo #(.buff_Depth(buff_Depth)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[v]),
            .push_data (flit_i),
            .pop       (pop[v]),
            .full      (full[v]),
            .empty     (empty[v]),
            .front     (front[v])
        );
    end

    // Per-VC write steering, request generation and stray-flit discard.
    always_comb begin
        push      = '0;
        request_o = '0;
        discard   = '0;
        for (int v = 0; v < vc_Num; v++) begin
            push[v]      = valid_i && (int'(flit_i.vc_id) == v);
            request_o[v] = (state[v] == VC_ACTIVE) && !empty[v];
            discard[v]   = (state[v] == VC_IDLE) && !empty[v] && !is_head(front[v].ftype);
        end
    end

    // Honour only the lowest-index grant that matches a live request.
    always_comb begin
        grant_pop = '0;
        sel_flit  = '0;
        for (int v = 0; v < vc_Num; v++) begin
            if (grant_i[v] && request_o[v] && (grant_pop == '0)) begin
                grant_pop[v] = 1'b1;
                sel_flit     = front[v];
            end
        end
    end

    assign pop       = grant_pop | discard;
    assign grant_err = (|(grant_i & ~request_o)) || ($countones(grant_i) > 1);
    assign drop_err  = |(push & full & ~pop);

    // Per-VC packet FSM: latch the route on a head, release after the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < vc_Num; v++) begin
                state[v]      <= VC_IDLE;
                out_port_o[v] <= LOCAL;
            end
        end else begin
            for (int v = 0; v < vc_Num; v++) begin
                case (state[v])
                    VC_IDLE: begin
                        if (!empty[v] && is_head(front[v].ftype)) begin
                            out_port_o[v] <= xy_route(front[v].dest_x, front[v].dest_y,
                                                      coord_W'(cur_X), coord_W'(cur_Y));
                            state[v]      <= VC_ACTIVE;
                        end
                    end
                    VC_ACTIVE: begin
                        if (grant_pop[v] && is_tail(front[v].ftype)) state[v] <= VC_IDLE;
                    end
                    default: state[v] <= VC_IDLE;
                endcase
            end
        end
    end

    // Registered crossbar output, credit pulses and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o  <= 1'b0;
            flit_o   <= '0;
            credit_o <= '0;
            error_o  <= 1'b0;
        end else begin
            valid_o  <= |grant_pop;
            if (|grant_pop) flit_o <= sel_flit;
            credit_o <= pop;
            error_o  <= error_o || grant_err || drop_err || (|discard);
        end
    end

endmodule

// File: tb/tb_input_vc_unit.sv
// Directed testbench for input_vc_unit with the router placed at (1,1).
module tb_input_vc_unit;
    import params_noc::*;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    flit_t       flit_i;
    logic [3:0]  credit_o;
    logic [3:0]  request_o;
    inout_Port   out_port_o [3:0];
    logic [3:0]  grant_i;
    logic        valid_o;
    flit_t       flit_o;
    logic        error_o;

    int vectors;
    int miscompares;

    input_vc_unit #(
        .vc_Num     (4),
        .buff_Depth (4),
        .cur_X      (1),
        .cur_Y      (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .flit_i     (flit_i),
        .credit_o   (credit_o),
        .request_o  (request_o),
        .out_port_o (out_port_o),
        .grant_i    (grant_i),
        .valid_o    (valid_o),
        .flit_o     (flit_o),
        .error_o    (error_o)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk_flit(input flit_type_t t, input int vc, input int dx,
                                      input int dy, input int pl);
        flit_t f;
        f.ftype   = t;
        f.vc_id   = vc_id_W'(vc);
        f.dest_x  = coord_W'(dx);
        f.dest_y  = coord_W'(dy);
        f.payload = payload_W'(pl);
        return f;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        grant_i = '0;
        flit_i  = '0;
        rst_n   = 1'b0;
        cycle();
        rst_n   = 1'b1;
    endtask

    task automatic send(input flit_t f);
        valid_i = 1'b1;
        flit_i  = f;
        cycle();
        valid_i = 1'b0;
        flit_i  = '0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
        send(mk_flit(HEAD, 1, 3, 1, 16'h0100));
        send(mk_flit(BODY, 1, 0, 0, 16'h0101));
        send(mk_flit(BODY, 1, 0, 0, 16'h0102));
        send(mk_flit(BODY, 1, 0, 0, 16'h0103));
        @(negedge clk);
        vectors++;
        if (request_o !== 4'b0010 || out_port_o[1] !== EAST) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_req: got req=%b port=%0d expected req=0010 port=%0d",
                     request_o, out_port_o[1], EAST);
        end
        grant_i = 4'b0010;
        cycle();
        grant_i = '0;
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b1 || flit_o.payload !== 16'h0100 || credit_o !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_pop: got valid=%b payload=%h credit=%b expected 1/0100/0010",
                     valid_o, flit_o.payload, credit_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (request_o !== 4'b0000 || valid_o !== 1'b0 || flit_o !== flit_t'('0) ||
            credit_o !== 4'b0000 || error_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got req=%b valid=%b flit=%h credit=%b err=%b expected all zero",
                     request_o, valid_o, flit_o, credit_o, error_o);
        end
        for (int v = 0; v < 4; v++) begin
            vectors++;
            if (out_port_o[v] !== LOCAL) begin
                miscompares++;
                $display("[TB] FAIL reset_port%0d: got %0d expected %0d", v, out_port_o[v], LOCAL);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        cycle();
        cycle();
        @(negedge clk);
        vectors++;
        if (request_o !== 4'b0000 || valid_o !== 1'b0 || credit_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_after: got req=%b valid=%b credit=%b expected 0000/0/0000",
                     request_o, valid_o, credit_o);
        end
    endtask

    task automatic test_single_packet();
        flit_t f;
        $display("[TB] test_single_packet");
        do_reset();
        f = mk_flit(HEADTAIL, 2, 3, 1, 16'hBEEF);
        send(f);
        @(negedge clk);
        vectors++;
        if (request_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_t1_req: got %b expected 0000", request_o);
        end
        cycle();
        @(negedge clk);
        vectors++;
        if (request_o !== 4'b0100 || out_port_o[2] !== EAST) begin
            miscompares++;
            $display("[TB] FAIL single_t2: got req=%b port=%0d expected req=0100 port=%0d",
                     request_o, out_port_o[2], EAST);
        end
        grant_i = 4'b0100;
        cycle();
        grant_i = '0;
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b1 || flit_o !== f || credit_o !== 4'b0100 ||
            request_o !== 4'b0000 || error_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_t3: got valid=%b flit=%h credit=%b req=%b err=%b expected 1/%h/0100/0000/0",
                     valid_o, flit_o, credit_o, request_o, error_o, f);
        end
        cycle();
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b0 || credit_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_t4: got valid=%b credit=%b expected 0/0000", valid_o, credit_o);
        end
    endtask

    task automatic test_multi_flit();
        $display("[TB] test_multi_flit");
        do_reset();
        send(mk_flit(HEAD, 0, 1, 0, 1));
        send(mk_flit(BODY, 0, 0, 0, 2));
        send(mk_flit(BODY, 0, 0, 0, 3));
        send(mk_flit(TAIL, 0, 0, 0, 4));
        @(negedge clk);
        vectors++;
        if (request_o !== 4'b0001 || out_port_o[0] !== SOUTH) begin
            miscompares++;
            $display("[TB] FAIL multi_req: got req=%b port=%0d expected req=0001 port=%0d",
                     request_o, out_port_o[0], SOUTH);
        end
        for (int i = 0; i < 4; i++) begin
            grant_i = 4'b0001;
            cycle();
            grant_i = '0;
            @(negedge clk);
            vectors++;
            if (valid_o !== 1'b1 || flit_o.payload !== 16'(i + 1) || credit_o !== 4'b0001 ||
                out_port_o[0] !== SOUTH) begin
                miscompares++;
                $display("[TB] FAIL multi_pop%0d: got valid=%b payload=%0d credit=%b port=%0d expected 1/%0d/0001/%0d",
                         i, valid_o, flit_o.payload, credit_o, out_port_o[0], i + 1, SOUTH);
            end
        end
        vectors++;
        if (request_o !== 4'b0000 || error_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL multi_done: got req=%b err=%b expected 0000/0", request_o, error_o);
        end
        cycle();
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL multi_idle_valid: got %b expected 0", valid_o);
        end
    endtask

    task automatic test_full_fifo();
        int exp_pl [4] = '{2, 3, 4, 6};
        $display("[TB] test_full_fifo");
        do_reset();
        send(mk_flit(HEAD, 3, 1, 1, 1));
        send(mk_flit(BODY, 3, 0, 0, 2));
        send(mk_flit(BODY, 3, 0, 0, 3));
        send(mk_flit(BODY, 3, 0, 0, 4));
        @(negedge clk);
        vectors++;
        if (error_o !== 1'b0 || request_o !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL full_before: got err=%b req=%b expected 0/1000", error_o, request_o);
        end
        send(mk_flit(BODY, 3, 0, 0, 5));
        @(negedge clk);
        vectors++;
        if (error_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_drop_err: got %b expected 1", error_o);
        end
        valid_i = 1'b1;
        flit_i  = mk_flit(BODY, 3, 0, 0, 6);
        grant_i = 4'b1000;
        cycle();
        valid_i = 1'b0;
        flit_i  = '0;
        grant_i = '0;
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b1 || flit_o.payload !== 16'd1 || credit_o !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL full_push_pop: got valid=%b payload=%0d credit=%b expected 1/1/1000",
                     valid_o, flit_o.payload, credit_o);
        end
        for (int i = 0; i < 4; i++) begin
            grant_i = 4'b1000;
            cycle();
            grant_i = '0;
            @(negedge clk);
            vectors++;
            if (valid_o !== 1'b1 || flit_o.payload !== 16'(exp_pl[i])) begin
                miscompares++;
                $display("[TB] FAIL full_drain%0d: got valid=%b payload=%0d expected 1/%0d",
                         i, valid_o, flit_o.payload, exp_pl[i]);
            end
        end
        vectors++;
        if (request_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL full_empty_req: got %b expected 0000", request_o);
        end
    endtask

    task automatic test_interleaved();
        logic [3:0] g_seq  [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        int         vc_seq [4] = '{0, 1, 0, 1};
        int         pl_seq [4] = '{10, 20, 11, 21};
        $display("[TB] test_interleaved");
        do_reset();
        send(mk_flit(HEAD, 0, 1, 1, 10));
        send(mk_flit(HEAD, 1, 0, 1, 20));
        send(mk_flit(TAIL, 0, 0, 0, 11));
        send(mk_flit(TAIL, 1, 0, 0, 21));
        @(negedge clk);
        vectors++;
        if (request_o !== 4'b0011 || out_port_o[0] !== LOCAL || out_port_o[1] !== WEST) begin
            miscompares++;
            $display("[TB] FAIL inter_req: got req=%b p0=%0d p1=%0d expected 0011/%0d/%0d",
                     request_o, out_port_o[0], out_port_o[1], LOCAL, WEST);
        end
        for (int i = 0; i < 4; i++) begin
            grant_i = g_seq[i];
            cycle();
            grant_i = '0;
            @(negedge clk);
            vectors++;
            if (valid_o !== 1'b1 || int'(flit_o.vc_id) != vc_seq[i] ||
                flit_o.payload !== 16'(pl_seq[i])) begin
                miscompares++;
                $display("[TB] FAIL inter_pop%0d: got valid=%b vc=%0d payload=%0d expected 1/%0d/%0d",
                         i, valid_o, flit_o.vc_id, flit_o.payload, vc_seq[i], pl_seq[i]);
            end
        end
        vectors++;
        if (request_o !== 4'b0000 || error_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL inter_done: got req=%b err=%b expected 0000/0", request_o, error_o);
        end
    endtask

    task automatic test_protocol_errors();
        $display("[TB] test_protocol_errors");
        do_reset();
        send(mk_flit(BODY, 1, 0, 0, 7));
        @(negedge clk);
        vectors++;
        if (error_o !== 1'b0 || credit_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL stray_before: got err=%b credit=%b expected 0/0000", error_o, credit_o);
        end
        cycle();
        @(negedge clk);
        vectors++;
        if (credit_o !== 4'b0010 || error_o !== 1'b1 || valid_o !== 1'b0 || request_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL stray_discard: got credit=%b err=%b valid=%b req=%b expected 0010/1/0/0000",
                     credit_o, error_o, valid_o, request_o);
        end
        cycle();
        @(negedge clk);
        vectors++;
        if (credit_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL stray_after: got credit=%b expected 0000", credit_o);
        end

        do_reset();
        send(mk_flit(HEADTAIL, 0, 1, 2, 30));
        send(mk_flit(HEADTAIL, 1, 2, 1, 31));
        cycle();
        @(negedge clk);
        vectors++;
        if (request_o !== 4'b0011 || out_port_o[0] !== NORTH || out_port_o[1] !== EAST ||
            error_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL multihot_pre: got req=%b p0=%0d p1=%0d err=%b expected 0011/%0d/%0d/0",
                     request_o, out_port_o[0], out_port_o[1], error_o, NORTH, EAST);
        end
        grant_i = 4'b0011;
        cycle();
        grant_i = '0;
        @(negedge clk);
        vectors++;
        if (valid_o !== 1'b1 || flit_o.vc_id !== 2'd0 || flit_o.payload !== 16'd30 ||
            credit_o !== 4'b0001 || error_o !== 1'b1 || request_o !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL multihot_post: got valid=%b vc=%0d pl=%0d credit=%b err=%b req=%b expected 1/0/30/0001/1/0010",
                     valid_o, flit_o.vc_id, flit_o.payload, credit_o, error_o, request_o);
        end

        do_reset();
        grant_i = 4'b0100;
        cycle();
        grant_i = '0;
        @(negedge clk);
        vectors++;
        if (error_o !== 1'b1 || valid_o !== 1'b0 || credit_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL stray_grant: got err=%b valid=%b credit=%b expected 1/0/0000",
                     error_o, valid_o, credit_o);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        valid_i     = 1'b0;
        flit_i      = '0;
        grant_i     = '0;
        test_reset();
        test_single_packet();
        test_multi_flit();
        test_full_fifo();
        test_interleaved();
        test_protocol_errors();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_vc_unit.md
# input_vc_unit

Input-side virtual-channel unit for one router input port: buffers arriving flits per VC, performs XY route computation on head flits, and drives per-VC requests and output-port selections into the switch allocator. It consumes the allocator's per-VC grant to dequeue the winning flit toward the crossbar and returns one credit per dequeued flit to the upstream router. One instance per router input port; its `request_o`/`out_port_o` feed `request_in[p]`/`inports_Out[p]`, and `grant_i` is driven from `grant_o[p]`.

## Interface
- `vc_Num`, 4, number of virtual channels per port.
- `buff_Depth`, 4, flit slots per VC FIFO (power of two, ≥2).
- `cur_X`, 0, this router's X coordinate.
- `cur_Y`, 0, this router's Y coordinate.

- `clk`  in  1  — single clock, all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `valid_i`  in  1  — `flit_i` valid this cycle.
- `flit_i`  in  `flit_t`  — incoming flit; `vc_id` field selects the VC FIFO.
- `credit_o`  out  `vc_Num`  — one-cycle pulse per VC slot freed.
- `request_o`  out  `vc_Num`  — per-VC allocation request.
- `out_port_o`  out  `inout_Port [vc_Num-1:0]`  — routed output port per VC.
- `grant_i`  in  `vc_Num`  — allocator grant, at most one bit set.
- `valid_o`  out  1  — `flit_o` valid toward crossbar.
- `flit_o`  out  `flit_t`  — dequeued flit.
- `error_o`  out  1  — sticky protocol-error flag.

## Operation
- **Write:** `valid_i` pushes `flit_i` into FIFO `flit_i.vc_id`.
  - If that FIFO is full and no pop occurs that cycle, the flit is dropped and `error_o` is set.
  - Write and pop on the same VC in the same cycle are both honoured, including when the FIFO is full.
- **Per-VC FSM, IDLE:** `request_o[v]=0`.
  - If the FIFO front is HEAD or HEADTAIL, latch the XY route into `out_port_o[v]` and go to ACTIVE.
  - If the front is BODY or TAIL, pop and discard it, pulse `credit_o[v]`, set `error_o`, and stay in IDLE.
- **Per-VC FSM, ACTIVE:** `request_o[v]` = FIFO non-empty. `out_port_o[v]` is held until the packet completes.
  - On `grant_i[v]` with `request_o[v]=1`: pop the front flit.
  - If the popped flit is TAIL or HEADTAIL, return to IDLE.
- **XY route:**
  - `dest_x>cur_X` → EAST; `dest_x<cur_X` → WEST.
  - Otherwise `dest_y>cur_Y` → NORTH; `dest_y<cur_Y` → SOUTH.
  - Otherwise → LOCAL.
- **Grant checking:**
  - A grant on a VC with `request_o=0` is ignored and sets `error_o`.
  - A multi-hot grant: only the lowest-index requesting VC is popped, and `error_o` is set.
- **Pointers:** read/write pointers are log2(`buff_Depth`) bits and wrap modulo depth. Fullness is tracked with a count of width log2(`buff_Depth`)+1.
- **Error flag:** `error_o` clears only on reset.

## Timing
- **Reset values** (asserted asynchronously, any cycle, including mid-packet):
  - All FIFOs empty, all FSMs IDLE.
  - `request_o=0`, `out_port_o=LOCAL` for every VC.
  - `valid_o=0`, `flit_o='0`, `credit_o=0`, `error_o=0`.
  - Any in-flight packet is lost.
- **Latency:** head written at cycle t → front visible t+1 (IDLE latches route) → ACTIVE with `request_o` high at t+2.
- `request_o`/`out_port_o` are registered-state outputs; the allocator returns `grant_i` combinationally in the same cycle.
- **Dequeue:** grant at cycle g → `flit_o`/`valid_o` registered at g+1, `credit_o[v]` pulse at g+1. `valid_o=0` on every cycle following a grant-free cycle.
- **Back-to-back:** consecutive grants on one VC drain one flit per cycle. The next packet's head after a tail takes one IDLE cycle before it requests.

## Structure
- `params_noc` (existing package) holds `in_Port_Cnt` and `inout_Port` (LOCAL/NORTH/SOUTH/EAST/WEST).
- Add to `params_noc`:
  - `flit_type_t` enum: HEAD, BODY, TAIL, HEADTAIL.
  - `flit_t` struct: type, `vc_id`, `dest_x`, `dest_y`, payload.
  - Coordinate width constants.
- One sub-module, `vc_fifo` (parameter `buff_Depth`; push/pop/full/empty/front), instantiated `vc_Num` times in a generate loop. FSMs, routing and grant logic stay in `input_vc_unit`.

## Test plan
- **Reset:** assert `rst_n=0` mid-packet with VC1 holding 3 flits → all outputs at reset values; after release VC1 empty, no requests.
- **Single packet:** `cur_X=1,cur_Y=1`; HEADTAIL to (3,1) on VC2 at t → `request_o=4'b0100`, `out_port_o[2]=EAST` at t+2; grant at t+2 → `valid_o`, `credit_o=4'b0100` at t+3, `request_o=0`.
- **Multi-flit packet:** 4-flit packet on VC0 to (1,0) with grants every cycle → SOUTH held, 4 consecutive `valid_o` cycles, 4 credits, IDLE after tail.
- **Full FIFO:** 5 writes to VC3 with depth 4 and no grant → 5th dropped, `error_o=1`. Write plus grant on the full FIFO → no drop, count stays 4.
- **Interleaved VCs:** VC0 to LOCAL (1,1), VC1 to WEST (0,1), grants alternating → `flit_o` vc_ids alternate, packet order preserved per VC.
- **Protocol errors:** BODY at front in IDLE → discarded with credit, `error_o=1`. Grant `4'b0011` with both requesting → only VC0 popped, `error_o=1`.
